led_p2s: RTL and testbench

Parallel-to-serial shifter that takes the LED/GPIO output word produced by the peripheral output register and clocks it out to the board's cascaded 74HC595-style shift registers. It sits directly downstream of the PIO output register, with `data_in` wired to its LED or GPIO word and `start` driven by the register's write enable. It generates shift clock, serial data, latch strobe and clear, and reports `busy`/`done` to the system.

---
 rtl/led_p2s_pkg.sv | 22 ++
 rtl/led_p2s_phase.sv | 33 +++
 rtl/led_p2s.sv | 116 +++++++++++
 tb/tb_led_p2s.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_p2s_pkg.sv
// led_p2s_pkg: shared definitions for the LED/GPIO parallel-to-serial shifter.
//   state_t      - FSM encodings (IDLE/SHIFT/LATCH)
//   DEF_WIDTH    - default bits per frame
//   DEF_DIV      - default s_clk half-period in clk cycles
//   frame_cycles - cycles from start sample to the done pulse, for bus-side timing
package led_p2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 2;

  // start sampled in cycle 0 -> done high in the returned cycle
  function automatic int frame_cycles(input int width, input int div);
    return width * 2 * div + div + 1;
  endfunction

endpackage

// File: rtl/led_p2s_phase.sv
// p2s_phase: s_clk phase counter for led_p2s.
//   clk, rst - system clock, async active-low reset
//   clr      - force ph to 0 (takes priority over en)
//   en       - advance ph, wrapping 2*DIV-1 -> 0
//   tc       - ph is at its terminal value 2*DIV-1 (s_clk falling point)
//   half     - ph is at DIV-1 (s_clk rising point; also end of latch window)
module p2s_phase #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic half
);

  localparam int PHW = $clog2(2 * DIV);
  localparam logic [PHW-1:0] PH_TC   = PHW'(2 * DIV - 1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(DIV - 1);

  logic [PHW-1:0] ph;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ph <= '0;
    else if (clr)      ph <= '0;
    else if (en)       ph <= (ph == PH_TC) ? '0 : ph + 1'b1;
  end

  assign tc   = (ph == PH_TC);
  assign half = (ph == PH_HALF);

endmodule

// File: rtl/led_p2s.sv
// led_p2s: shifts a parallel LED/GPIO word out to cascaded 74HC595-style
// registers, MSB first, then strobes the storage latch.
//   clk, rst   - system clock, async active-low reset
//   start      - frame request (queued as pending if a frame is running)
//   data_in    - parallel word, captured when a frame is accepted
//   busy, done - frame in progress / one-cycle completion pulse
//   s_clk      - serial shift clock
//   s_dat      - serial data, changes only on s_clk falling points
//   s_latch    - storage latch strobe, active high
//   s_clr_n    - external clear, low while in reset
// All outputs are registers; each is loaded with the value it must show in
// the following cycle.
module led_p2s
  import led_p2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             s_clk,
  output logic             s_dat,
  output logic             s_latch,
  output logic             s_clr_n
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] BC_LAST = BCW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [BCW-1:0]   bc;
  logic             pending;
  logic             ph_tc, ph_half, ph_clr, ph_en;

  // ph idles at 0 and is re-zeroed when the latch window ends; the
  // SHIFT->LATCH hand-off relies on the natural wrap at tc.
  assign ph_en  = (state != ST_IDLE);
  assign ph_clr = (state == ST_IDLE) || (state == ST_LATCH && ph_half);

  p2s_phase #(.DIV(DIV)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .clr  (ph_clr),
    .en   (ph_en),
    .tc   (ph_tc),
    .half (ph_half)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bc      <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_dat   <= 1'b0;
      s_latch <= 1'b0;
      s_clr_n <= 1'b0;
    end else begin
      s_clr_n <= 1'b1;
      done    <= 1'b0;
      // requests during a frame collapse into a single queued frame
      if (start && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          // s_clr_n still low means this is the first cycle out of reset
          if (s_clr_n && (start || pending)) begin
            state   <= ST_SHIFT;
            sr      <= data_in;
            bc      <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
            s_clk   <= 1'b0;
            s_dat   <= data_in[WIDTH-1];
          end else begin
            s_dat   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ph_half) s_clk <= 1'b1;
          if (ph_tc) begin
            // falling s_clk: present next bit; after the last bit this
            // yields 0 since only fill zeros remain below the MSB
            s_clk <= 1'b0;
            sr    <= {sr[WIDTH-2:0], 1'b0};
            s_dat <= sr[WIDTH-2];
            if (bc == BC_LAST) begin
              state   <= ST_LATCH;
              bc      <= '0;
              s_latch <= 1'b1;
            end else begin
              bc <= bc + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          if (ph_half) begin
            state   <= ST_IDLE;
            s_latch <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_p2s.sv
module tb_led_p2s;

  logic clk, rst;
  logic start, start2;
  logic [7:0]  data_in;
  logic [15:0] data2;
  logic busy, done, s_clk, s_dat, s_latch, s_clr_n;
  logic busy2, done2, s_clk2, s_dat2, s_latch2, s_clr_n2;

  led_p2s #(.WIDTH(8), .DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .s_clk(s_clk), .s_dat(s_dat),
    .s_latch(s_latch), .s_clr_n(s_clr_n)
  );

  led_p2s #(.WIDTH(16), .DIV(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data2),
    .busy(busy2), .done(done2), .s_clk(s_clk2), .s_dat(s_dat2),
    .s_latch(s_latch2), .s_clr_n(s_clr_n2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // per-run observation stats
  int busy_first, busy_last, busy_cnt, br_cnt;
  int br_c[4];
  int latch_first, latch_last, latch_cnt;
  int done_cnt;
  int done_c[4];
  int rise_cnt, overlap, dat_viol, dat0, tog_viol;
  logic [63:0] bits;
  logic p_busy, p_clk, p_dat, p_latch;

  task automatic clr_stats();
    busy_first = -1; busy_last = -1; busy_cnt = 0; br_cnt = 0;
    latch_first = -1; latch_last = -1; latch_cnt = 0;
    done_cnt = 0; rise_cnt = 0; overlap = 0; dat_viol = 0; dat0 = 0; tog_viol = 0;
    bits = '0;
    for (int i = 0; i < 4; i++) begin br_c[i] = -1; done_c[i] = -1; end
    p_busy = 0; p_clk = 0; p_dat = 0; p_latch = 0;
  endtask

  task automatic sample(input int c, input logic b, input logic d, input logic sc,
                        input logic sd, input logic sl);
    if (b && !p_busy) begin if (br_cnt < 4) br_c[br_cnt] = c; br_cnt++; end
    if (b) begin if (busy_cnt == 0) busy_first = c; busy_last = c; busy_cnt++; end
    if (sl) begin if (latch_cnt == 0) latch_first = c; latch_last = c; latch_cnt++; end
    if (d) begin if (done_cnt < 4) done_c[done_cnt] = c; done_cnt++; end
    if (sc && !p_clk) begin rise_cnt++; bits = {bits[62:0], sd}; end
    if (sl && sc) overlap++;
    if (sd !== p_dat && p_busy && !(p_clk && !sc)) dat_viol++;
    if (b && !sl && !sd) dat0++;
    if (p_busy && b && !sl && sc == p_clk) tog_viol++;
    p_busy = b; p_clk = sc; p_dat = sd; p_latch = sl;
  endtask

  // two consecutive idle samples on both DUTs (a done cycle alone is not idle)
  task automatic wait_idle(input string nm);
    int idle_run;
    idle_run = 0;
    for (int i = 0; i < 300 && idle_run < 2; i++) begin
      @(negedge clk);
      idle_run = (!busy && !busy2) ? idle_run + 1 : 0;
      @(posedge clk); #1;
    end
    n_chk++;
    if (idle_run < 2) $display("FAIL %s_idle_timeout got=busy expected=idle", nm);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 0; start = 0; start2 = 0; data_in = 8'h00; data2 = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++; if ({busy, done, s_clk, s_dat, s_latch, s_clr_n} !== 6'b0)
      $display("FAIL rst_outputs got=%b expected=000000", {busy, done, s_clk, s_dat, s_latch, s_clr_n});
    else n_pass++;
    n_chk++; if ({busy2, done2, s_clk2, s_dat2, s_latch2, s_clr_n2} !== 6'b0)
      $display("FAIL rst_outputs2 got=%b expected=000000", {busy2, done2, s_clk2, s_dat2, s_latch2, s_clr_n2});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1; start = 1; data_in = 8'h5A;
    @(negedge clk);
    n_chk++; if (s_clr_n !== 1'b0)
      $display("FAIL rst_clr_before_edge got=%b expected=0", s_clr_n);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (s_clr_n !== 1'b1)
      $display("FAIL rst_clr_rise got=%b expected=1", s_clr_n);
    else n_pass++;
    n_chk++; if (busy !== 1'b0)
      $display("FAIL rst_first_start_ignored got=%b expected=0", busy);
    else n_pass++;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1)
      $display("FAIL rst_second_start_accepted got=%b expected=1", busy);
    else n_pass++;
    @(posedge clk); #1;
    wait_idle("rst");
  endtask

  task automatic test_single();
    clr_stats();
    data_in = 8'hA5;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0);
      @(negedge clk); sample(c, busy, done, s_clk, s_dat, s_latch);
      @(posedge clk); #1;
    end
    start = 0;
    n_chk++; if (rise_cnt !== 8) $display("FAIL single_rises got=%0d expected=8", rise_cnt); else n_pass++;
    n_chk++; if (bits[7:0] !== 8'hA5) $display("FAIL single_bits got=%h expected=a5", bits[7:0]); else n_pass++;
    n_chk++; if (latch_first !== 33 || latch_last !== 34 || latch_cnt !== 2)
      $display("FAIL single_latch got=%0d..%0d n=%0d expected=33..34 n=2", latch_first, latch_last, latch_cnt);
    else n_pass++;
    n_chk++; if (done_cnt !== 1 || done_c[0] !== 35)
      $display("FAIL single_done got=n%0d@%0d expected=n1@35", done_cnt, done_c[0]);
    else n_pass++;
    n_chk++; if (busy_first !== 1 || busy_last !== 34 || busy_cnt !== 34)
      $display("FAIL single_busy got=%0d..%0d n=%0d expected=1..34 n=34", busy_first, busy_last, busy_cnt);
    else n_pass++;
    n_chk++; if (overlap !== 0 || dat_viol !== 0)
      $display("FAIL single_timing got=ovl%0d dv%0d expected=ovl0 dv0", overlap, dat_viol);
    else n_pass++;
  endtask

  task automatic test_pending();
    clr_stats();
    for (int c = 0; c < 80; c++) begin
      start = (c == 0 || c == 10 || c == 20);
      data_in = (c >= 30) ? 8'h80 : 8'h01;
      @(negedge clk); sample(c, busy, done, s_clk, s_dat, s_latch);
      @(posedge clk); #1;
    end
    start = 0;
    n_chk++; if (br_cnt !== 2) $display("FAIL pend_frames got=%0d expected=2", br_cnt); else n_pass++;
    n_chk++; if (br_c[1] !== 36) $display("FAIL pend_second_start got=%0d expected=36", br_c[1]); else n_pass++;
    n_chk++; if (bits[15:0] !== 16'h0180) $display("FAIL pend_bits got=%h expected=0180", bits[15:0]); else n_pass++;
    n_chk++; if (done_cnt !== 2 || done_c[0] !== 35 || done_c[1] !== 70)
      $display("FAIL pend_done got=n%0d@%0d,%0d expected=n2@35,70", done_cnt, done_c[0], done_c[1]);
    else n_pass++;
    wait_idle("pend");
  endtask

  task automatic test_back_to_back();
    clr_stats();
    data_in = 8'hFF;
    for (int c = 0; c < 107; c++) begin
      start = 1;
      @(negedge clk); sample(c, busy, done, s_clk, s_dat, s_latch);
      @(posedge clk); #1;
    end
    start = 0;
    n_chk++; if (br_c[0] !== 1 || br_c[1] !== 36 || br_c[2] !== 71)
      $display("FAIL b2b_period got=%0d,%0d,%0d expected=1,36,71", br_c[0], br_c[1], br_c[2]);
    else n_pass++;
    n_chk++; if (done_cnt !== 3 || done_c[2] !== 105)
      $display("FAIL b2b_done got=n%0d@%0d expected=n3@105", done_cnt, done_c[2]);
    else n_pass++;
    n_chk++; if (dat0 !== 0) $display("FAIL b2b_dat_low got=%0d expected=0", dat0); else n_pass++;
    n_chk++; if (overlap !== 0) $display("FAIL b2b_latch_overlap got=%0d expected=0", overlap); else n_pass++;
    n_chk++; if (rise_cnt !== 24 || bits[23:0] !== 24'hFFFFFF)
      $display("FAIL b2b_bits got=n%0d %h expected=n24 ffffff", rise_cnt, bits[23:0]);
    else n_pass++;
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    clr_stats();
    data_in = 8'hA5;
    for (int c = 0; c < 50; c++) begin
      start = (c == 0);
      if (c == 12) begin
        rst = 0;
        #1;
        n_chk++; if ({busy, done, s_clk, s_dat, s_latch, s_clr_n} !== 6'b0)
          $display("FAIL mid_async_clear got=%b expected=000000", {busy, done, s_clk, s_dat, s_latch, s_clr_n});
        else n_pass++;
      end
      if (c == 15) rst = 1;
      @(negedge clk); sample(c, busy, done, s_clk, s_dat, s_latch);
      @(posedge clk); #1;
    end
    start = 0;
    n_chk++; if (latch_cnt !== 0 || done_cnt !== 0)
      $display("FAIL mid_no_latch_done got=l%0d d%0d expected=l0 d0", latch_cnt, done_cnt);
    else n_pass++;
    clr_stats();
    data_in = 8'h3C;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0);
      @(negedge clk); sample(c, busy, done, s_clk, s_dat, s_latch);
      @(posedge clk); #1;
    end
    start = 0;
    n_chk++; if (rise_cnt !== 8 || bits[7:0] !== 8'h3C)
      $display("FAIL mid_next_bits got=n%0d %h expected=n8 3c", rise_cnt, bits[7:0]);
    else n_pass++;
    n_chk++; if (done_cnt !== 1 || done_c[0] !== 35 || latch_cnt !== 2)
      $display("FAIL mid_next_done got=n%0d@%0d l%0d expected=n1@35 l2", done_cnt, done_c[0], latch_cnt);
    else n_pass++;
  endtask

  task automatic test_corner();
    clr_stats();
    data2 = 16'h8001;
    for (int c = 0; c < 40; c++) begin
      start2 = (c == 0);
      @(negedge clk); sample(c, busy2, done2, s_clk2, s_dat2, s_latch2);
      @(posedge clk); #1;
    end
    start2 = 0;
    n_chk++; if (tog_viol !== 0) $display("FAIL corner_toggle got=%0d expected=0", tog_viol); else n_pass++;
    n_chk++; if (rise_cnt !== 16 || bits[15:0] !== 16'h8001)
      $display("FAIL corner_bits got=n%0d %h expected=n16 8001", rise_cnt, bits[15:0]);
    else n_pass++;
    n_chk++; if (done_cnt !== 1 || done_c[0] !== 34)
      $display("FAIL corner_done got=n%0d@%0d expected=n1@34", done_cnt, done_c[0]);
    else n_pass++;
    n_chk++; if (latch_first !== 33 || latch_cnt !== 1)
      $display("FAIL corner_latch got=%0d n%0d expected=33 n1", latch_first, latch_cnt);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    test_corner();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
